// File: rtl/spi_slave_out_pkg.sv
// Shared definitions for the SPI slave datapath: FSM encodings, synchroniser depth
// and the SPI mode that both the transmitter and the receiver implement.
package spi_slave_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  localparam logic       SPI_CPOL = 1'b0;
  localparam logic       SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with one history flop so the
// caller gets the synchronised level plus single-cycle rise/fall strobes.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_out.sv
// SPI mode-0 slave transmitter: shifts a BITS-wide word out on miso, MSB first,
// with cs and sck oversampled in the clk domain.
module spi_slave_out
  import spi_slave_out_pkg::*;
#(
  parameter int unsigned BITS        = 32,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            sck,
  input  logic [BITS-1:0] in_buf,
  output logic            miso,
  output logic            miso_oe,
  output logic            busy,
  output logic            done,
  output logic            abort
);

  localparam int unsigned CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;

  // Reset to 0 so a cs held low across reset release never looks like a falling edge.
  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_cs_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (cs),
    .level(cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sck_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (sck),
    .level(sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  logic unused_levels;
  assign unused_levels = cs_s ^ sck_s;

  state_e          state_q;
  logic [BITS-1:0] shreg_q;
  logic [CW-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            shreg_q <= in_buf;
            cnt_q   <= '0;
            miso    <= in_buf[BITS-1];
            miso_oe <= 1'b1;
            busy    <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT, ST_DRAIN: begin
          // cs_rise has priority: any sck edge in the same cycle is dropped.
          if (cs_rise) begin
            state_q <= ST_IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= (cnt_q == CNT_FULL);
            abort   <= (cnt_q != CNT_FULL);
          end else if (state_q == ST_DRAIN) begin
            miso <= 1'b0;
          end else if (sck_rise) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_DRAIN;
              miso    <= 1'b0;
            end
          end else if (sck_fall && cnt_q < CNT_FULL) begin
            shreg_q <= {shreg_q[BITS-2:0], 1'b0};
            miso    <= shreg_q[BITS-2];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_out.sv
// Randomised self-checking bench for spi_slave_out acting as an SPI mode-0 host.
module tb_spi_slave_out;

  localparam int unsigned BITS = 32;
  localparam int unsigned SYNC = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cs = 1'b1;
  logic            sck = 1'b0;
  logic [BITS-1:0] in_buf = '0;
  logic            miso, miso_oe, busy, done, abort;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_out #(
    .BITS       (BITS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .sck    (sck),
    .in_buf (in_buf),
    .miso   (miso),
    .miso_oe(miso_oe),
    .busy   (busy),
    .done   (done),
    .abort  (abort)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (abort) abort_cnt++;
    if ((done && abort) || ((done || abort) && busy)) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host-side frame: reads nbits MSB-first on sck rises; optional in_buf swap and cs/sck tie.
  task automatic run_frame(input string tag, input logic [BITS-1:0] word, input int nbits,
                           input int half, input int swap_at, input logic [BITS-1:0] swap_word,
                           input bit tie);
    logic [63:0] rx, ex;
    int d0, a0, counted;
    bit exp_done;
    rx = '0;
    ex = '0;
    in_buf = word;
    cs = 1'b1;
    wait_clk(4);
    d0 = done_cnt;
    a0 = abort_cnt;
    cs = 1'b0;
    wait_clk(SYNC);
    check({tag, ":oe_early"}, 64'(miso_oe), 64'd0);
    wait_clk(1);
    check({tag, ":oe_start"}, 64'(miso_oe), 64'd1);
    check({tag, ":busy_start"}, 64'(busy), 64'd1);
    check({tag, ":miso_first"}, 64'(miso), 64'(word[BITS-1]));
    wait_clk(2);
    for (int i = 0; i < nbits; i++) begin
      ex = {ex[62:0], (i < int'(BITS)) ? word[BITS-1-i] : 1'b0};
      rx = {rx[62:0], miso};
      sck = 1'b1;
      if (tie && i == nbits - 1) cs = 1'b1;
      wait_clk(half);
      sck = 1'b0;
      if (i + 1 == swap_at) in_buf = swap_word;
      wait_clk(half);
    end
    check({tag, ":data"}, rx, ex);
    wait_clk(2);
    cs = 1'b1;
    wait_clk(SYNC + 3);
    counted = tie ? nbits - 1 : nbits;
    exp_done = (counted >= int'(BITS));
    check({tag, ":done"}, 64'(done_cnt - d0), 64'(exp_done));
    check({tag, ":abort"}, 64'(abort_cnt - a0), 64'(!exp_done));
    check({tag, ":busy_end"}, 64'(busy), 64'd0);
    check({tag, ":oe_end"}, 64'(miso_oe), 64'd0);
    check({tag, ":miso_end"}, 64'(miso), 64'd0);
  endtask

  initial begin
    int d0, a0, oe_seen;
    wait_clk(3);
    check("rst:miso", 64'(miso), 64'd0);
    check("rst:oe", 64'(miso_oe), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:abort", 64'(abort), 64'd0);
    reset = 1'b1;
    wait_clk(4);

    run_frame("basic", 32'hA5C3_0F81, 32, 4, 0, '0, 1'b0);
    run_frame("short", 32'hFFFF_FFFF, 12, 4, 0, '0, 1'b0);
    run_frame("over", 32'h0000_0001, 40, 4, 0, '0, 1'b0);
    run_frame("stable", 32'h1234_5678, 32, 4, 4, 32'hDEAD_BEEF, 1'b0);
    run_frame("second", in_buf, 32, 4, 0, '0, 1'b0);
    check("second:word", 64'(in_buf), 64'h0000_0000_DEAD_BEEF);

    // Reset in the middle of a frame, then a cs held low across release.
    in_buf = $urandom;
    cs = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 10; i++) begin
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
      wait_clk(4);
    end
    d0 = done_cnt;
    a0 = abort_cnt;
    reset = 1'b0;
    wait_clk(1);
    check("rstmid:miso", 64'(miso), 64'd0);
    check("rstmid:oe", 64'(miso_oe), 64'd0);
    check("rstmid:busy", 64'(busy), 64'd0);
    wait_clk(3);
    reset = 1'b1;
    oe_seen = 0;
    for (int i = 0; i < 10; i++) begin
      sck = ~sck;
      for (int k = 0; k < 4; k++) begin
        wait_clk(1);
        if (miso_oe || busy) oe_seen++;
      end
    end
    check("rstmid:no_frame", 64'(oe_seen), 64'd0);
    check("rstmid:no_pulse", 64'((done_cnt - d0) + (abort_cnt - a0)), 64'd0);
    run_frame("after_rst", 32'hC001_D00D, 32, 4, 0, '0, 1'b0);

    run_frame("tie", $urandom, 32, 4, 0, '0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      int nb;
      nb = $urandom_range(1, 40);
      run_frame($sformatf("rand%0d", r), $urandom, nb, $urandom_range(4, 6),
                $urandom_range(1, nb), $urandom, 1'b0);
    end

    check("pulse_overlap", 64'(overlap_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_out.md
Name: spi_slave_out

Overview:
- SPI slave transmitter (mode 0, MSB first). It lets an external host read a BITS-wide status word out of the chip, such as config readback, pv or stimulus telemetry.
- It is the transmit counterpart of the existing configuration slave receiver and shares the host-side cs and sck.
- The host samples miso on rising sck. The block updates miso after each falling sck.
- All pin inputs are oversampled in the clk domain. There is no logic clocked by sck.

Parameters:
- BITS, 32, width of the readback word and of each frame.
- SYNC_STAGES, 2, synchroniser flops on cs and sck. Minimum 2.

Ports:
- clk  input  1  system clock. Must be at least 4x the sck frequency.
- reset  input  1  synchronous, active-low: when reset==0 at posedge clk, all state returns to idle.
- cs  input  1  host chip select, active-low, asynchronous pin.
- sck  input  1  host serial clock, asynchronous pin, idles low.
- in_buf  input  BITS  word to transmit. Sampled only at frame start.
- miso  output  1  serial data out.
- miso_oe  output  1  pad drive enable. High only while a frame is in progress.
- busy  output  1  frame in progress.
- done  output  1  one-clk pulse: frame ended after exactly BITS sck rising edges.
- abort  output  1  one-clk pulse: frame ended with fewer than BITS rising edges.

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, busy=0, done=0, abort=0.
  - State IDLE, shift register 0, bit counter 0.
  - cs synchroniser flops reset to 0 and sck synchroniser flops reset to 0.
  - Consequence: if cs is held low through reset release, no frame starts. A frame starts only after cs_s has been seen high and then low.
- Synchronisation: cs_s and sck_s are the last synchroniser stages. One extra flop per signal gives prev values. Edges are cs_fall, cs_rise, sck_rise and sck_fall, each evaluated per clk.
- States:
  - IDLE: miso=0, oe=0, busy=0.
    - On cs_fall: shreg<=in_buf, cnt<=0, go SHIFT.
    - miso<=in_buf[BITS-1], oe<=1 and busy<=1 all take effect on the same edge.
    - Latency from the cs pin falling to miso valid is SYNC_STAGES+1 clk cycles.
  - SHIFT:
    - On sck_rise: cnt<=cnt+1. The host samples here.
    - On sck_fall, if cnt<BITS: shreg<=shreg<<1 with zero fill, and miso<=next bit, i.e. the new shreg[BITS-1].
    - When cnt reaches BITS: go DRAIN.
    - cnt is wide enough to hold BITS without wrap, i.e. clog2(BITS+1) bits.
  - DRAIN: miso<=0. Further sck edges are ignored, so over-clocking reads zeros. oe stays 1 and busy stays 1.
  - Exit from SHIFT or DRAIN on cs_rise:
    - Go IDLE; miso<=0, oe<=0, busy<=0 on that edge.
    - done<=1 for one cycle if cnt==BITS, else abort<=1 for one cycle.
- Simultaneous events: if cs_rise occurs in the same cycle as an sck edge, cs_rise wins and the sck edge is dropped.
- in_buf changes during a frame have no effect on that frame. A new cs_fall after IDLE loads the current in_buf.
- cs glitch shorter than one clk after synchronisation: no frame.
- Reset mid-frame (reset==0): immediate return to IDLE with reset values. No done or abort pulse is emitted.
- done and abort are never high together. Neither is high while busy==1 except on the exit cycle, where busy has already dropped.

Decomposition:
- Shared include/package holds:
  - state encodings: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DRAIN=2'd2;
  - default SYNC_STAGES;
  - the SPI mode constant (CPOL=0, CPHA=0), shared with the receiver.
- One sub-module, spi_pin_sync:
  - parameterised SYNC_STAGES;
  - reset value as a parameter;
  - outputs: synchronised level, rise strobe and fall strobe.
  - It is instantiated twice, for cs and sck. The receiver is expected to adopt it later.

Test Plan:
- Basic frame: reset, in_buf=32'hA5C3_0F81, cs low, then 32 sck cycles at clk/8.
  - The bench samples miso on each sck rise and must read 0xA5C30F81 MSB first.
  - cs high -> done pulses once, abort=0, busy=0, miso_oe=0.
- Short frame: in_buf=32'hFFFF_FFFF, 12 sck cycles, then cs high -> 12 ones read, abort pulses once, done=0.
- Over-clock: in_buf=32'h0000_0001, 40 sck cycles -> bit 31 read as 1, the 8 extra bits read as 0, done pulses once at cs high.
- Buffer stability: cs low with in_buf=32'h1234_5678, change in_buf to 32'hDEAD_BEEF after 4 bits -> 0x12345678 read.
  - A second frame then reads 0xDEADBEEF.
- Reset mid-frame: reset=0 after 10 bits with cs still low -> miso=0, oe=0, busy=0, no done or abort.
  - Release reset with cs low and clock sck -> no frame starts and miso_oe stays 0.
  - Then cs high, cs low -> a normal frame follows.
- Tie: cs rise in the same clk as an sck rise at bit 32 (cnt=31) -> the rise is dropped and abort pulses, not done.
